// File: rtl/prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: widths, fetch FSM states, FIFO entry layout.
// No logic here; used by prefetch_queue and pq_fifo.
// Backpressure is not applicable to a package.
package prefetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int WORD_W  = 16;
  localparam int ADDR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_HI = 2'd1,
    ST_REQ_LO = 2'd2
  } fetch_state_t;

  // One queued instruction: assembled 32-bit word plus the address of its upper half.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } pq_entry_t;

endpackage

// File: rtl/pq_fifo.sv
// Instruction FIFO: DEPTH entries of {instr, pc}, with push/pop/clear and occupancy outputs.
// Latency: a push is visible at the head (and in count/empty) one cycle after the push edge.
// Backpressure: push is accepted only when not full or when a pop happens in the same cycle.
module pq_fifo
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        push,
  input  pq_entry_t                   push_dat,
  input  logic                        pop,
  output pq_entry_t                   head_dat,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pq_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage write; entries need no reset since count gates their visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy tracking; clear (flush) empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Prefetch stage: fetches 16-bit word pairs, assembles 32-bit instructions, queues them for decode.
// Latency: instruction is valid one cycle after the lo-word ack; one instruction per 2 cycles at best.
// Backpressure: a fetch starts only when a FIFO slot is free; decoder consumes via ir_valid/ir_take.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int              DEPTH      = 4,
  parameter logic [15:0]     RESET_ADDR = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [WORD_W-1:0]  mem_data,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_addr,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_take
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [ADDR_W-1:0]   fetch_ptr;
  logic [WORD_W-1:0]   hi_word;
  logic                capture_hi;
  logic                push;
  logic                ir_pop;
  logic                space_after;
  pq_entry_t           push_dat;
  pq_entry_t           head_dat;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  assign ir_pop = ir_take && ir_valid;
  // In REQ_LO our own slot is already counted as reserved, so the check is on the
  // occupancy after this push (and any same-cycle pop) lands.
  assign space_after = (fifo_count + CNT_W'(1) - CNT_W'(ir_pop)) < CNT_W'(DEPTH);
  assign push_dat    = '{instr: {hi_word, mem_data}, pc: fetch_ptr - ADDR_W'(1)};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush always returns to IDLE so fetching restarts a cycle later.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!fifo_full) state_nxt = ST_REQ_HI;
      ST_REQ_HI: if (mem_ack)    state_nxt = ST_REQ_LO;
      ST_REQ_LO: if (mem_ack)    state_nxt = space_after ? ST_REQ_HI : ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // FSM outputs: request is held stable for the whole state; acks during flush are dropped.
  always_comb begin
    mem_req    = (state == ST_REQ_HI) || (state == ST_REQ_LO);
    mem_addr   = mem_req ? fetch_ptr : '0;
    capture_hi = (state == ST_REQ_HI) && mem_ack && !flush;
    push       = (state == ST_REQ_LO) && mem_ack && !flush;
  end

  // Fetch address and upper-half holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_ptr <= RESET_ADDR;
      hi_word   <= '0;
    end else if (flush) begin
      fetch_ptr <= flush_addr;
      hi_word   <= '0;
    end else if (mem_req && mem_ack) begin
      fetch_ptr <= fetch_ptr + ADDR_W'(1);
      if (capture_hi) hi_word <= mem_data;
    end
  end

  pq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (push),
    .push_dat (push_dat),
    .pop      (ir_pop),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign ir_valid = !fifo_empty;
  assign ir_out   = ir_valid ? head_dat.instr : '0;
  assign ir_pc    = ir_valid ? head_dat.pc    : '0;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a combinational memory model.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Memory ack is driven explicitly by the stimulus sequence.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        flush;
  logic [15:0] flush_addr;
  logic [31:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_take;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  function automatic logic [31:0] pair(input logic [15:0] a);
    logic [15:0] b;
    b = a + 16'd1;
    return {mem_word(a), mem_word(b)};
  endfunction

  assign mem_data = mem_word(mem_addr);

  prefetch_queue #(.DEPTH(4), .RESET_ADDR(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .flush      (flush),
    .flush_addr (flush_addr),
    .ir_out     (ir_out),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_take    (ir_take)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   48'(mem_req),  48'h0);
    check({tag, "_addr"},  48'(mem_addr), 48'h0);
    check({tag, "_valid"}, 48'(ir_valid), 48'h0);
    check({tag, "_out"},   48'(ir_out),   48'h0);
    check({tag, "_pc"},    48'(ir_pc),    48'h0);
    check({tag, "_count"}, 48'(dut.fifo_count), 48'h0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; flush_addr = 16'h0; ir_take = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");

    // 1. Fill with ack tied high: addresses 0..7, valid rises after first lo ack.
    reset = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("fill_req", 48'(mem_req), 48'h1);
      check("fill_addr", 48'(mem_addr), 48'(i));
      check("fill_valid", 48'(ir_valid), (i >= 2) ? 48'h1 : 48'h0);
    end
    tick();
    check("full_req", 48'(mem_req), 48'h0);
    check("full_count", 48'(dut.fifo_count), 48'h4);
    check("full_out", 48'(ir_out), 48'(pair(16'h0000)));
    check("full_pc", 48'(ir_pc), 48'h0);
    tick();
    check("full_idle", 48'(mem_req), 48'h0);

    // 2. One take from a full queue refills exactly one pair (8,9).
    ir_take = 1'b1;
    tick();
    ir_take = 1'b0;
    check("take_count", 48'(dut.fifo_count), 48'h3);
    check("take_pc", 48'(ir_pc), 48'h2);
    check("take_out", 48'(ir_out), 48'(pair(16'h0002)));
    tick();
    check("refill_hi", 48'({mem_req, mem_addr}), 48'h1_0008);
    tick();
    check("refill_lo", 48'({mem_req, mem_addr}), 48'h1_0009);
    tick();
    check("refill_idle", 48'(mem_req), 48'h0);
    check("refill_count", 48'(dut.fifo_count), 48'h4);
    tick();
    check("refill_stop", 48'(mem_req), 48'h0);

    // Drain with ack held low; heads come out in pc order 4,6,8.
    mem_ack = 1'b0;
    ir_take = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_pc", 48'(ir_pc), 48'(4 + 2 * i));
    end
    tick();
    ir_take = 1'b0;
    check("drain_empty", 48'(ir_valid), 48'h0);
    check("drain_pc0", 48'(ir_pc), 48'h0);

    // 3. Delayed ack: request held stable 3 cycles per word, instruction lands after lo ack.
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check("slow_hold", 48'({mem_req, mem_addr}), 48'h1_0000 | 48'(10 + w));
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("slow_count", 48'(dut.fifo_count), 48'((w + 1) / 2));
    end
    check("slow_out", 48'(ir_out), 48'(pair(16'd10)));
    check("slow_pc", 48'(ir_pc), 48'd10);

    // 4. Flush in REQ_LO with a same-cycle ack and take: nothing pushed, restart at 0x0100.
    mem_ack = 1'b1;
    tick();
    check("pre_flush_lo", 48'({mem_req, mem_addr}), 48'h1_000F);
    flush = 1'b1; flush_addr = 16'h0100; ir_take = 1'b1;
    tick();
    flush = 1'b0; ir_take = 1'b0;
    check("flush_valid", 48'(ir_valid), 48'h0);
    check("flush_count", 48'(dut.fifo_count), 48'h0);
    check("flush_req", 48'(mem_req), 48'h0);
    check("flush_out", 48'(ir_out), 48'h0);
    tick();
    check("flush_restart", 48'({mem_req, mem_addr}), 48'h1_0100);
    tick();
    tick();
    check("flush_push_valid", 48'(ir_valid), 48'h1);
    check("flush_push_out", 48'(ir_out), 48'(pair(16'h0100)));
    check("flush_push_pc", 48'(ir_pc), 48'h0100);
    check("flush_push_count", 48'(dut.fifo_count), 48'h1);

    // 6a. count=1 with push and take together: count and valid hold.
    tick();
    check("pp_lo", 48'({mem_req, mem_addr}), 48'h1_0103);
    ir_take = 1'b1;
    tick();
    ir_take = 1'b0;
    check("pp_valid", 48'(ir_valid), 48'h1);
    check("pp_count", 48'(dut.fifo_count), 48'h1);
    check("pp_pc", 48'(ir_pc), 48'h0102);
    check("pp_next", 48'({mem_req, mem_addr}), 48'h1_0104);

    // 5. Address wrap across the hi/lo pair.
    flush = 1'b1; flush_addr = 16'hFFFF;
    tick();
    flush = 1'b0;
    check("wrap_flush_valid", 48'(ir_valid), 48'h0);
    tick();
    check("wrap_hi", 48'({mem_req, mem_addr}), 48'h1_FFFF);
    tick();
    check("wrap_lo", 48'({mem_req, mem_addr}), 48'h1_0000);
    tick();
    check("wrap_pc", 48'(ir_pc), 48'hFFFF);
    check("wrap_out", 48'(ir_out), 48'({mem_word(16'hFFFF), mem_word(16'h0000)}));
    check("wrap_next", 48'({mem_req, mem_addr}), 48'h1_0001);

    // 6b. Reset mid-REQ_HI.
    mem_ack = 1'b0;
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    tick();
    check("post_reset_req", 48'({mem_req, mem_addr}), 48'h1_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
